// File: rtl/texel_arbiter_pkg.sv
// Shared types for the texel arbiter: FSM states, the triangle/colour payload,
// and a width helper that stays at least one bit wide.
package defines_package;

   typedef enum logic {
      ARB_IDLE,
      ARB_SEND
   } arb_state_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } Vertex3D;

   typedef struct packed {
      Vertex3D v0;
      Vertex3D v1;
      Vertex3D v2;
   } Triangle3D;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } Color;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/texel_arbiter_rr_pick.sv
// Round-robin picker: first requesting index after 'last', scanning upward
// with wrap, so 'last' itself is considered only after every other source.
module rr_pick
   import defines_package::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = cnt_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any
);

   int               idx;
   logic [SRC_W-1:0] sel;

   // Scan from farthest to nearest so the nearest requester wins the final write.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int i = NUM_SRC; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_SRC;
         sel = SRC_W'(idx);
         if (req[sel]) begin
            gnt_idx = sel;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/texel_arbiter.sv
// Shares the clip/split input between NUM_SRC texel sources: round-robin with
// optional burst, registers the winner's triangle and holds it until consumed.
//
// state    | meaning
// ARB_IDLE | no triangle presented; arbitrate and capture when any source is ready
// ARB_SEND | registered triangle presented; wait for texel_read
module texel_arbiter
   import defines_package::*;
#(
   parameter int NUM_SRC = 4,
   parameter int BURST   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          src_ready,
   input  Triangle3D                   src_vertices [NUM_SRC],
   input  Color                        src_color    [NUM_SRC],
   output logic [NUM_SRC-1:0]          src_read,
   output logic                        texel_ready,
   output Triangle3D                   texel_vertices_out,
   output Color                        texel_color_out,
   input  logic                        texel_read,
   output logic [$clog2(NUM_SRC)-1:0]  grant_idx,
   output logic                        busy
);

   localparam int               SRC_W    = $clog2(NUM_SRC);
   localparam int               BC_W     = cnt_width(BURST);
   localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_SRC - 1);

   arb_state_t         state_q, state_d;
   logic [SRC_W-1:0]   last_grant_q, last_grant_d;
   logic [SRC_W-1:0]   grant_q, grant_d;
   logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic [NUM_SRC-1:0] src_read_q, src_read_d;
   Triangle3D          vert_q, vert_d;
   Color               color_q, color_d;

   logic [SRC_W-1:0]   rr_idx;
   logic               any_req;
   logic               burst_hit;
   logic [SRC_W-1:0]   pick_idx;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_pick (
      .req     (src_ready),
      .last    (last_grant_q),
      .gnt_idx (rr_idx),
      .any     (any_req)
   );

   // Staying on the previous winner only while it is still ready and has burst budget left.
   always_comb begin
      burst_hit = (BURST > 1) && src_ready[last_grant_q] && (int'(burst_cnt_q) < BURST - 1);
      pick_idx  = burst_hit ? last_grant_q : rr_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= LAST_RST;
         grant_q      <= '0;
         burst_cnt_q  <= '0;
         src_read_q   <= '0;
         vert_q       <= '0;
         color_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         burst_cnt_q  <= burst_cnt_d;
         src_read_q   <= src_read_d;
         vert_q       <= vert_d;
         color_q      <= color_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      burst_cnt_d  = burst_cnt_q;
      src_read_d   = '0;
      vert_d       = vert_q;
      color_d      = color_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               state_d      = ARB_SEND;
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               burst_cnt_d  = burst_hit ? burst_cnt_q + 1'b1 : '0;
               src_read_d   = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
               vert_d       = src_vertices[pick_idx];
               color_d      = src_color[pick_idx];
            end
         end
         ARB_SEND: begin
            if (texel_read) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      texel_ready        = (state_q == ARB_SEND);
      busy               = (state_q == ARB_SEND);
      src_read           = src_read_q;
      grant_idx          = grant_q;
      texel_vertices_out = vert_q;
      texel_color_out    = color_q;
   end

endmodule

// File: tb/tb_texel_arbiter.sv
// Directed bench for texel_arbiter: a pure round-robin instance and a BURST=3
// instance share stimulus; each step compares against hand-derived values.
module tb_texel_arbiter;
   import defines_package::*;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    src_ready;
   Triangle3D       src_vertices [N];
   Color            src_color    [N];
   logic            texel_read;

   logic [N-1:0]    rr_src_read, bu_src_read;
   logic            rr_ready, bu_ready;
   Triangle3D       rr_vert, bu_vert;
   Color            rr_col, bu_col;
   logic [1:0]      rr_gnt, bu_gnt;
   logic            rr_busy, bu_busy;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   texel_arbiter #(.NUM_SRC(N), .BURST(1)) u_rr (
      .clk(clk), .rst(rst), .src_ready(src_ready), .src_vertices(src_vertices),
      .src_color(src_color), .src_read(rr_src_read), .texel_ready(rr_ready),
      .texel_vertices_out(rr_vert), .texel_color_out(rr_col), .texel_read(texel_read),
      .grant_idx(rr_gnt), .busy(rr_busy)
   );

   texel_arbiter #(.NUM_SRC(N), .BURST(3)) u_bu (
      .clk(clk), .rst(rst), .src_ready(src_ready), .src_vertices(src_vertices),
      .src_color(src_color), .src_read(bu_src_read), .texel_ready(bu_ready),
      .texel_vertices_out(bu_vert), .texel_color_out(bu_col), .texel_read(texel_read),
      .grant_idx(bu_gnt), .busy(bu_busy)
   );

   function automatic Triangle3D exp_vert(input int i);
      return {36{4'(i + 1)}};
   endfunction

   function automatic Color exp_col(input int i);
      return {6{4'(i + 9)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int bexp [7] = '{0, 0, 0, 1, 1, 1, 0};

   initial begin
      rst        = 1'b1;
      src_ready  = '0;
      texel_read = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_vertices[i] = exp_vert(i);
         src_color[i]    = exp_col(i);
      end

      // 1: reset state, then single request from src 0
      tick();
      chk("rst_ready", rr_ready, 0);
      chk("rst_busy", rr_busy, 0);
      chk("rst_gnt", rr_gnt, 0);
      chk("rst_read", rr_src_read, 0);
      chk("rst_vert", rr_vert, 0);
      rst        = 1'b0;
      src_ready  = 4'b0001;
      texel_read = 1'b1;
      tick();
      chk("t1_ready", rr_ready, 1);
      chk("t1_busy", rr_busy, 1);
      chk("t1_gnt", rr_gnt, 0);
      chk("t1_read", rr_src_read, 4'b0001);
      chk("t1_vert", rr_vert, exp_vert(0));
      chk("t1_col", rr_col, exp_col(0));
      src_ready = 4'b0000;
      tick();
      chk("t1_ready_drop", rr_ready, 0);
      chk("t1_read_once", rr_src_read, 0);
      tick();
      chk("t1_idle_stays", rr_ready, 0);

      // 2: all ready, pure round-robin, one triangle per two cycles
      do_reset();
      src_ready  = 4'b1111;
      texel_read = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t2_ready", rr_ready, 1);
         chk("t2_gnt", rr_gnt, k % 4);
         chk("t2_read", rr_src_read, 4'b0001 << (k % 4));
         chk("t2_vert", rr_vert, exp_vert(k % 4));
         tick();
         chk("t2_gap", rr_ready, 0);
      end

      // 3: two sources ready; burst instance repeats up to three times
      src_ready = 4'b0000;
      do_reset();
      src_ready = 4'b0011;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("t3_bu_ready", bu_ready, 1);
         chk("t3_bu_gnt", bu_gnt, bexp[k]);
         chk("t3_rr_gnt", rr_gnt, k % 2);
         tick();
         chk("t3_bu_gap", bu_ready, 0);
      end

      // 4: hold in ARB_SEND while inputs churn
      src_ready = 4'b0000;
      do_reset();
      src_ready  = 4'b0100;
      texel_read = 1'b0;
      tick();
      chk("t4_gnt", rr_gnt, 2);
      chk("t4_read_first", rr_src_read, 4'b0100);
      for (int k = 0; k < 10; k++) begin
         src_vertices[2] = {36{4'(k + 5)}};
         src_ready       = 4'(k);
         tick();
         chk("t4_hold_vert", rr_vert, exp_vert(2));
         chk("t4_hold_ready", rr_ready, 1);
         chk("t4_no_reread", rr_src_read, 0);
      end
      src_ready       = 4'b0000;
      src_vertices[2] = exp_vert(2);
      texel_read      = 1'b1;
      tick();
      chk("t4_exit", rr_ready, 0);

      // 5: reset in the third ARB_SEND cycle
      do_reset();
      src_ready  = 4'b0100;
      texel_read = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_send3", rr_ready, 1);
      chk("t5_send3_gnt", rr_gnt, 2);
      src_ready = 4'b0000;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_ready", rr_ready, 0);
      chk("t5_busy", rr_busy, 0);
      chk("t5_read", rr_src_read, 0);
      chk("t5_vert", rr_vert, 0);
      src_ready  = 4'b1111;
      texel_read = 1'b1;
      tick();
      chk("t5_regrant", rr_gnt, 0);
      chk("t5_regrant_read", rr_src_read, 4'b0001);

      // 6: wrap scan reaches the last winner itself, then wraps to 0
      src_ready = 4'b0000;
      do_reset();
      src_ready  = 4'b1000;
      texel_read = 1'b1;
      tick();
      chk("t6_gnt_a", rr_gnt, 3);
      tick();
      chk("t6_gap", rr_ready, 0);
      tick();
      chk("t6_gnt_b", rr_gnt, 3);
      chk("t6_read_b", rr_src_read, 4'b1000);
      src_ready = 4'b0001;
      tick();
      chk("t6_gap2", rr_ready, 0);
      tick();
      chk("t6_gnt_c", rr_gnt, 0);
      chk("t6_read_c", rr_src_read, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
